// File: rtl/rnd_pkg.sv
// Shared widths, rounding-mode encodings and the request bundle type used by
// the rounder arbiter and other shared FPU resources.
package rnd_pkg;

  localparam int ER_W   = 13;
  localparam int FR_W   = 57;
  localparam int FLR_W  = 58;
  localparam int RM_W   = 2;
  localparam int FP_W   = 64;
  localparam int FLAG_W = 5;

  localparam logic [RM_W-1:0] RM_RNE = 2'b00;
  localparam logic [RM_W-1:0] RM_RTZ = 2'b01;
  localparam logic [RM_W-1:0] RM_RUP = 2'b10;
  localparam logic [RM_W-1:0] RM_RDN = 2'b11;

  typedef struct packed {
    logic             db;
    logic             s;
    logic [ER_W-1:0]  er;
    logic [FR_W-1:0]  fr;
    logic [FLR_W-1:0] flr;
    logic [RM_W-1:0]  rm;
    logic             ovfen;
    logic             unfen;
  } rnd_req_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: scans from ptr with wrap, returns a one-hot
// grant, its index, and the pointer to use next cycle when advance is set.
module rr_arb #(
  parameter int NREQ = 3,
  localparam int SRC_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [SRC_W-1:0] idx,
  output logic             found,
  output logic [SRC_W-1:0] ptr_nxt
);

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = SRC_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (advance) ptr_nxt = (int'(idx) == NREQ - 1) ? '0 : idx + SRC_W'(1);
  end

endmodule

// File: rtl/rnd_arbiter.sv
// Shares one combinational IEEE rounder among NREQ producers: round-robin pick,
// register onto rounder inputs, capture result. Optional RND_STICKY_FLAGS_EN.
module rnd_arbiter
  import rnd_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int TAG_W = 4,
  localparam int SRC_W = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_db,
  input  logic [NREQ-1:0]         req_s,
  input  logic [NREQ*ER_W-1:0]    req_er,
  input  logic [NREQ*FR_W-1:0]    req_fr,
  input  logic [NREQ*FLR_W-1:0]   req_flr,
  input  logic [NREQ*RM_W-1:0]    req_rm,
  input  logic [NREQ-1:0]         req_ovfen,
  input  logic [NREQ-1:0]         req_unfen,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  output logic                    rnd_db,
  output logic                    rnd_s,
  output logic                    rnd_ovfen,
  output logic                    rnd_unfen,
  output logic [ER_W-1:0]         rnd_er,
  output logic [FR_W-1:0]         rnd_fr,
  output logic [FLR_W-1:0]        rnd_flr,
  output logic [RM_W-1:0]         rnd_rm,
  input  logic [FP_W-1:0]         rnd_fp,
  input  logic [FLAG_W-1:0]       rnd_ieeep,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [FP_W-1:0]         res_fp,
  output logic [FLAG_W-1:0]       res_ieeep,
  output logic [SRC_W-1:0]        res_src,
  output logic [TAG_W-1:0]        res_tag,
  input  logic                    flag_clr,
  output logic [FLAG_W-1:0]       sticky_flags
);

  logic [NREQ-1:0]  grant;
  logic [SRC_W-1:0] win_idx, ptr, ptr_nxt, a_src;
  logic [TAG_W-1:0] a_tag;
  logic             any_req, a_valid, b_valid, a_free, b_free, accept, xfer, drain;
  rnd_req_t         sel, a_req;

  assign b_free = !b_valid || res_ready;
  assign a_free = !a_valid || b_free;
  // Gate with rst so nothing is offered while reset is held.
  assign accept = any_req && a_free && !rst;
  assign xfer   = a_valid && b_free;
  assign drain  = b_valid && res_ready;

  assign req_ready = accept ? grant : '0;
  assign res_valid = b_valid;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .advance (accept),
    .grant   (grant),
    .idx     (win_idx),
    .found   (any_req),
    .ptr_nxt (ptr_nxt)
  );

  always_comb begin
    sel       = '0;
    sel.db    = req_db[win_idx];
    sel.s     = req_s[win_idx];
    sel.er    = req_er[win_idx*ER_W +: ER_W];
    sel.fr    = req_fr[win_idx*FR_W +: FR_W];
    sel.flr   = req_flr[win_idx*FLR_W +: FLR_W];
    sel.rm    = req_rm[win_idx*RM_W +: RM_W];
    sel.ovfen = req_ovfen[win_idx];
    sel.unfen = req_unfen[win_idx];
  end

  assign rnd_db    = a_req.db;
  assign rnd_s     = a_req.s;
  assign rnd_er    = a_req.er;
  assign rnd_fr    = a_req.fr;
  assign rnd_flr   = a_req.flr;
  assign rnd_rm    = a_req.rm;
  assign rnd_ovfen = a_req.ovfen;
  assign rnd_unfen = a_req.unfen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      a_valid <= 1'b0;
      a_req   <= '0;
      a_src   <= '0;
      a_tag   <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (accept) begin
        a_valid <= 1'b1;
        a_req   <= sel;
        a_src   <= win_idx;
        a_tag   <= req_tag[win_idx*TAG_W +: TAG_W];
      end else if (xfer) begin
        a_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid   <= 1'b0;
      res_fp    <= '0;
      res_ieeep <= '0;
      res_src   <= '0;
      res_tag   <= '0;
    end else if (xfer) begin
      b_valid   <= 1'b1;
      res_fp    <= rnd_fp;
      res_ieeep <= rnd_ieeep;
      res_src   <= a_src;
      res_tag   <= a_tag;
    end else if (drain) begin
      b_valid <= 1'b0;
    end
  end

`ifdef RND_STICKY_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_flags <= '0;
    else if (flag_clr) sticky_flags <= drain ? res_ieeep : '0;
    else if (drain) sticky_flags <= sticky_flags | res_ieeep;
  end
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign sticky_flags    = '0;
`endif

endmodule

// File: tb/tb_rnd_arbiter.sv
// Directed bench for rnd_arbiter with a pass-through rounder stub; sticky-flag
// expectations follow RND_STICKY_FLAGS_EN.
module tb_rnd_arbiter;
  localparam int NREQ  = 3;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_db = '0, req_s = '0, req_ovfen = '0, req_unfen = '0;
  logic [NREQ*13-1:0] req_er = '0;
  logic [NREQ*57-1:0] req_fr = '0;
  logic [NREQ*58-1:0] req_flr = '0;
  logic [NREQ*2-1:0]  req_rm = '0;
  logic [NREQ*TAG_W-1:0] req_tag = '0;
  logic              rnd_db, rnd_s, rnd_ovfen, rnd_unfen;
  logic [12:0]       rnd_er;
  logic [56:0]       rnd_fr;
  logic [57:0]       rnd_flr;
  logic [1:0]        rnd_rm;
  logic [63:0]       rnd_fp;
  logic [4:0]        rnd_ieeep;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [63:0]       res_fp;
  logic [4:0]        res_ieeep;
  logic [1:0]        res_src;
  logic [TAG_W-1:0]  res_tag;
  logic              flag_clr = 1'b0;
  logic [4:0]        sticky_flags;

  int checks = 0;
  int errors = 0;
  logic [63:0] fr_hold;

  always #5 clk = ~clk;

  assign rnd_fp    = {7'b0, rnd_fr};
  assign rnd_ieeep = rnd_flr[4:0];

  rnd_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_db(req_db), .req_s(req_s), .req_er(req_er), .req_fr(req_fr),
    .req_flr(req_flr), .req_rm(req_rm), .req_ovfen(req_ovfen), .req_unfen(req_unfen),
    .req_tag(req_tag), .rnd_db(rnd_db), .rnd_s(rnd_s), .rnd_ovfen(rnd_ovfen),
    .rnd_unfen(rnd_unfen), .rnd_er(rnd_er), .rnd_fr(rnd_fr), .rnd_flr(rnd_flr),
    .rnd_rm(rnd_rm), .rnd_fp(rnd_fp), .rnd_ieeep(rnd_ieeep), .res_valid(res_valid),
    .res_ready(res_ready), .res_fp(res_fp), .res_ieeep(res_ieeep), .res_src(res_src),
    .res_tag(res_tag), .flag_clr(flag_clr), .sticky_flags(sticky_flags)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [56:0] fr, input logic [4:0] fl,
                         input logic [3:0] tg);
    req_fr[i*57 +: 57]       = fr;
    req_flr[i*58 +: 58]      = {53'b0, fl};
    req_tag[i*TAG_W +: TAG_W] = tg;
  endtask

  initial begin
    // Reset state, with requests present to confirm nothing is offered.
    req_valid = 3'b111;
    step();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_rnd_fr", 64'(rnd_fr), 64'h0);
    chk("rst_res_fp", res_fp, 64'h0);
    chk("rst_res_src", 64'(res_src), 64'h0);
    chk("rst_sticky", 64'(sticky_flags), 64'h0);
    req_valid = '0;
    rst = 1'b0;
    step();

    // Single request from requester 1.
    res_ready = 1'b1;
    set_req(1, 57'h1234, 5'b00100, 4'hA);
    req_valid = 3'b010;
    #1;
    chk("single_grant", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    chk("single_a_res_valid", 64'(res_valid), 64'h0);
    chk("single_rnd_fr", 64'(rnd_fr), 64'h1234);
    step();
    chk("single_res_valid", 64'(res_valid), 64'h1);
    chk("single_res_fp", res_fp, 64'h1234);
    chk("single_res_ieeep", 64'(res_ieeep), 64'h4);
    chk("single_res_src", 64'(res_src), 64'h1);
    chk("single_res_tag", 64'(res_tag), 64'hA);
    step();
    chk("single_drained", 64'(res_valid), 64'h0);

    // Stall with both stages full; ptr is now 2.
    set_req(0, 57'h100, 5'b0, 4'h5);
    set_req(1, 57'h101, 5'b0, 4'h6);
    set_req(2, 57'h102, 5'b0, 4'h7);
    res_ready = 1'b0;
    req_valid = 3'b111;
    #1;
    chk("stall_grant0", 64'(req_ready), 64'h4);
    step();
    req_valid = 3'b011;
    #1;
    chk("stall_grant1", 64'(req_ready), 64'h1);
    step();
    req_valid = 3'b010;
    #1;
    chk("stall_full_ready", 64'(req_ready), 64'h0);
    chk("stall_res_src", 64'(res_src), 64'h2);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_hold_valid", 64'(res_valid), 64'h1);
      chk("stall_hold_fp", res_fp, 64'h102);
      chk("stall_hold_rnd_fr", 64'(rnd_fr), 64'h100);
      chk("stall_hold_ready", 64'(req_ready), 64'h0);
    end
    res_ready = 1'b1;
    #1;
    chk("release_grant", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    chk("release_src0", 64'(res_src), 64'h0);
    chk("release_fp0", res_fp, 64'h100);
    step();
    chk("release_src1", 64'(res_src), 64'h1);
    chk("release_fp1", res_fp, 64'h101);
    chk("release_tag1", 64'(res_tag), 64'h6);
    step();
    chk("release_empty", 64'(res_valid), 64'h0);

    // Reset while both stages full; ptr is 2 again.
    res_ready = 1'b0;
    req_valid = 3'b111;
    step();
    req_valid = 3'b011;
    step();
    req_valid = 3'b010;
    chk("prerst_full", 64'(res_valid), 64'h1);
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", 64'(res_valid), 64'h0);
    chk("midrst_req_ready", 64'(req_ready), 64'h0);
    chk("midrst_rnd_fr", 64'(rnd_fr), 64'h0);
    step();
    chk("midrst_held", 64'(res_valid), 64'h0);
    rst = 1'b0;
    res_ready = 1'b1;
    req_valid = 3'b111;
    #1;
    chk("postrst_grant", 64'(req_ready), 64'h1);
    chk("postrst_res_valid", 64'(res_valid), 64'h0);

    // Continuous stream: grants 0,1,2,0,1,2 and results in the same order.
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 4) req_valid = 3'b110;
      if (k == 5) req_valid = 3'b100;
      if (k == 6) req_valid = 3'b000;
      #1;
      if (k <= 5) chk("stream_grant", 64'(req_ready), 64'(1) << (k % 3));
      if (k >= 2 && k <= 7) begin
        chk("stream_valid", 64'(res_valid), 64'h1);
        chk("stream_src", 64'(res_src), 64'((k - 2) % 3));
        chk("stream_fp", res_fp, 64'h100 + 64'((k - 2) % 3));
        chk("stream_tag", 64'(res_tag), 64'h5 + 64'((k - 2) % 3));
      end
      if (k == 8) chk("stream_empty", 64'(res_valid), 64'h0);
    end

    // Only requester 2 with ptr=0, then confirm ptr wrapped back to 0.
    req_valid = 3'b100;
    #1;
    chk("wrap_grant2", 64'(req_ready), 64'h4);
    step();
    req_valid = 3'b011;
    #1;
    chk("wrap_ptr0", 64'(req_ready), 64'h1);
    step();
    req_valid = 3'b010;
    #1;
    chk("wrap_grant1", 64'(req_ready), 64'h2);
    chk("wrap_src2", 64'(res_src), 64'h2);
    step();
    req_valid = '0;
    chk("wrap_src0", 64'(res_src), 64'h0);
    step();
    chk("wrap_src1", 64'(res_src), 64'h1);
    step();
    chk("wrap_empty", 64'(res_valid), 64'h0);

    // Sticky flags: 00001 then 10000 accumulate; clear coinciding with 00100 drain.
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("sticky_cleared", 64'(sticky_flags), 64'h0);
    set_req(0, 57'h1, 5'b00001, 4'h0);
    req_valid = 3'b001;
    step();
    set_req(0, 57'h2, 5'b10000, 4'h0);
    step();
    set_req(0, 57'h3, 5'b00100, 4'h0);
    step();
    req_valid = '0;
    step();
    chk("sticky_res_ieeep", 64'(res_ieeep), 64'h4);
`ifdef RND_STICKY_FLAGS_EN
    chk("sticky_accum", 64'(sticky_flags), 64'h11);
`else
    chk("sticky_off_accum", 64'(sticky_flags), 64'h0);
`endif
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
`ifdef RND_STICKY_FLAGS_EN
    chk("sticky_clr_drain", 64'(sticky_flags), 64'h4);
`else
    chk("sticky_off_clr", 64'(sticky_flags), 64'h0);
`endif
    chk("sticky_empty", 64'(res_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
